// File: rtl/alarm_pkg.sv
// Shared types and timing constants for the alarm buzzer path.
// Cycle-count defaults are derived from CLK_HZ so a clock change only touches one line.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BEEP_ON,
        BEEP_OFF,
        GAP
    } state_t;

    localparam int CLK_HZ     = 100_000_000;
    localparam int CYC_PER_MS = CLK_HZ / 1000;
    localparam int TONE_HZ    = 2000;

    localparam int TONE_HALF_DEF = CLK_HZ / (2 * TONE_HZ);
    localparam int ON_CYC_DEF    = 200 * CYC_PER_MS;
    localparam int OFF_CYC_DEF   = 200 * CYC_PER_MS;
    localparam int GAP_CYC_DEF   = 1000 * CYC_PER_MS;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_buzzer_driver_tone_gen.sv
// Square-wave tone generator: registered output, phase restarts high on enable rise.
// Latency: output reflects en one cycle later. No backpressure; free-running while enabled.
// Output forced low whenever en is low.
module tone_gen #(
    parameter int TONE_HALF = 25000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tone
);

    localparam int HW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    logic [HW-1:0] hcnt;
    logic          en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            en_q <= 1'b0;
            tone <= 1'b0;
        end else begin
            en_q <= en;
            if (en && !en_q) begin
                tone <= 1'b1;
                hcnt <= '0;
            end else if (en) begin
                if (hcnt == HW'(TONE_HALF - 1)) begin
                    tone <= ~tone;
                    hcnt <= '0;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end else begin
                tone <= 1'b0;
                hcnt <= '0;
            end
        end
    end

endmodule

// File: rtl/alarm_buzzer_driver.sv
// Alarm pattern sequencer: tone-gated beeps grouped into bursts with gaps, until stop or timeout.
// Latency: trig to active/buzz_out high is 1 cycle; stop to idle is 1 cycle.
// No backpressure: trig ignored while active, stop always wins.
module alarm_buzzer_driver
    import alarm_pkg::*;
#(
    parameter int TONE_HALF  = TONE_HALF_DEF,
    parameter int ON_CYC     = ON_CYC_DEF,
    parameter int OFF_CYC    = OFF_CYC_DEF,
    parameter int BEEPS      = 4,
    parameter int GAP_CYC    = GAP_CYC_DEF,
    parameter int MAX_BURSTS = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic alarm_trig,
    input  logic stop,
    output logic buzz_out,
    output logic active,
    output logic done
);

    localparam int MAXC = max2(max2(ON_CYC, OFF_CYC), max2(GAP_CYC, TONE_HALF));
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int BW   = $clog2(max2(MAX_BURSTS, BEEPS) + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] beep_q, beep_d, beep_inc;
    logic [BW-1:0] burst_q, burst_d, burst_inc;
    logic          done_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beep_d    = beep_q;
        burst_d   = burst_q;
        done_d    = 1'b0;
        beep_inc  = beep_q + 1'b1;
        burst_inc = burst_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (alarm_trig && !stop) begin
                    state_d = BEEP_ON;
                    cnt_d   = '0;
                    beep_d  = '0;
                    burst_d = '0;
                end
            end
            BEEP_ON: begin
                if (cnt_q == CW'(ON_CYC - 1)) begin
                    cnt_d   = '0;
                    beep_d  = beep_inc;
                    state_d = (beep_inc == BW'(BEEPS)) ? GAP : BEEP_OFF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BEEP_OFF: begin
                if (cnt_q == CW'(OFF_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = BEEP_ON;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    cnt_d  = '0;
                    beep_d = '0;
                    if (MAX_BURSTS != 0 && burst_inc == BW'(MAX_BURSTS)) begin
                        state_d = IDLE;
                        burst_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = BEEP_ON;
                        // Unlimited mode: hold at all-ones instead of wrapping
                        if (burst_q != '1) burst_d = burst_inc;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            beep_d  = '0;
            burst_d = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beep_q  <= '0;
            burst_q <= '0;
            active  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beep_q  <= beep_d;
            burst_q <= burst_d;
            active  <= (state_d != IDLE);
            done    <= done_d;
        end
    end

    // Enable is the next state so the registered tone lines up with the state change
    tone_gen #(
        .TONE_HALF(TONE_HALF)
    ) u_tone (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state_d == BEEP_ON),
        .tone (buzz_out)
    );

endmodule

// File: doc/alarm_buzzer_driver.md
Name: alarm_buzzer_driver

Overview:
- Output-side counterpart to the button input conditioning.
- Turns a one-cycle alarm trigger into a patterned piezo drive. The pattern is a square-wave tone gated into beeps, beeps grouped into bursts, and bursts separated by silent gaps.
- Runs until a user stop pulse (from the debounced button path) or until a burst-count timeout.
- Sits between the alarm time-compare logic and the buzzer/LED pins.

Parameters:
- TONE_HALF, 25000: clk cycles per tone half-period (2 kHz at 100 MHz).
- ON_CYC, 20000000: clk cycles per beep (tone on).
- OFF_CYC, 20000000: clk cycles of silence between beeps within a burst.
- BEEPS, 4: beeps per burst (≥1).
- GAP_CYC, 100000000: clk cycles of silence after the last beep of a burst.
- MAX_BURSTS, 60: bursts before auto-timeout; 0 = unlimited.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- alarm_trig  in  1  single-cycle start pulse, synchronous to clk.
- stop  in  1  single-cycle stop pulse (debounced, edge-detected button), synchronous to clk.
- buzz_out  out  1  registered piezo drive.
- active  out  1  high while a pattern is running.
- done  out  1  single-cycle pulse when the pattern ends by timeout (not by stop).

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All outputs are registered.
- Reset values: buzz_out=0, active=0, done=0, state=IDLE, all counters 0.
- States: IDLE, BEEP_ON, BEEP_OFF, GAP.
- IDLE:
  - alarm_trig=1 and stop=0 → BEEP_ON at the next edge.
  - Latency is 1 cycle: at the edge following the trig cycle, active=1 and buzz_out=1.
  - The tone counter, beep counter and burst counter all clear.
- BEEP_ON:
  - Lasts exactly ON_CYC cycles.
  - buzz_out toggles every TONE_HALF cycles, starting high.
  - At the end of the beep the beep count increments.
  - If the beep count reaches BEEPS → GAP; otherwise → BEEP_OFF.
  - On exit buzz_out is forced to 0 at the same edge.
- BEEP_OFF:
  - Lasts exactly OFF_CYC cycles, buzz_out=0.
  - Then → BEEP_ON, with the tone phase restarted high.
- GAP:
  - Lasts exactly GAP_CYC cycles, buzz_out=0.
  - At the end, the burst count increments and the beep count clears.
  - If MAX_BURSTS≠0 and the burst count reaches MAX_BURSTS → IDLE, with active=0 and done=1 for one cycle.
  - Otherwise → BEEP_ON.
- stop=1 in any non-IDLE state:
  - → IDLE at the next edge.
  - buzz_out=0 and active=0 at that edge.
  - done stays 0.
- Simultaneous events:
  - stop and alarm_trig together in IDLE: stop wins, stay IDLE.
  - stop on the same cycle as a GAP timeout: stop wins, done=0.
- alarm_trig while active: ignored (no restart, no counter change).
- stop in IDLE: no effect.
- Reset mid-pattern: immediate return to reset values; no done pulse.
- Counter widths: $clog2 of the largest cycle parameter. Burst and beep counters use $clog2(max(MAX_BURSTS,BEEPS)+1). No counter may wrap while active.
- MAX_BURSTS=0: the burst counter saturates and is never compared for exit.

Decomposition:
- Shared package alarm_pkg holds:
  - the state enum (IDLE, BEEP_ON, BEEP_OFF, GAP);
  - the default CLK_HZ constant;
  - ms-to-cycles helper constants used by the top-level to set parameters.
- One natural sub-module: tone_gen (enable, half-period counter, square-wave output, phase reset on enable rise). The FSM and counters stay in alarm_buzzer_driver.

Test Plan:
Bench parameters: TONE_HALF=2, ON_CYC=8, OFF_CYC=4, BEEPS=2, GAP_CYC=10, MAX_BURSTS=2.
1. Trig pulse at cycle 0:
   - active=1 from cycle 1.
   - buzz_out pattern over cycles 1–8 is 1,1,0,0,1,1,0,0.
   - Cycles 9–12 are 0; second beep in cycles 13–20; gap in cycles 21–30.
   - Second burst starts at cycle 31.
2. Full run from scenario 1:
   - done=1 for exactly one cycle at cycle 61.
   - active falls at cycle 61.
   - 8 rising edges on buzz_out in total.
3. Stop pulse at cycle 5 (mid-beep):
   - buzz_out=0 and active=0 at cycle 6.
   - done never asserts.
   - A fresh trig at cycle 20 restarts with the tone phase high.
4. Trig and stop in the same cycle from IDLE: no activity. Trig pulses at cycles 3 and 10 during a run: pattern timing identical to scenario 1.
5. rst_n low for 2 cycles at cycle 15: outputs go 0 asynchronously, no done pulse, FSM in IDLE after release.
6. MAX_BURSTS=0: run 10 bursts (300 cycles) without done, then stop ends the pattern within 1 cycle.
